mux_4_arbiter: RTL and testbench

MUX_4_ARBITER -- requirements
Module: mux_4_arbiter

---
 rtl/mux_4_arbiter_if.sv | 23 ++
 rtl/mux_4_arbiter.sv | 118 +++++++++++
 tb/tb_mux_4_arbiter.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/mux_4_arbiter_if.sv
// rtl/mux_4_arbiter_if.sv - request/grant and shared data channel bundle for mux_4_arbiter
interface mux_4_arbiter_if;
  logic [3:0] req;
  logic       in0;
  logic       in1;
  logic       in2;
  logic       in3;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       valid;
  logic       out;
  logic       timeout;

  modport master (
    output req, in0, in1, in2, in3,
    input  gnt, sel, valid, out, timeout
  );

  modport slave (
    input  req, in0, in1, in2, in3,
    output gnt, sel, valid, out, timeout
  );
endinterface

// File: rtl/mux_4_arbiter.sv
// rtl/mux_4_arbiter.sv - four-requester round-robin arbiter driving a shared 1-bit channel
// Forced release after MAX_HOLD grant cycles is built in when MUX_ARB_TIMEOUT_EN is defined.
module mux_4_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic           clk,
  input  logic           reset,
  mux_4_arbiter_if.slave bus
);
  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] last_q, last_d;
  logic       valid_q, valid_d;
  logic       timeout_q, timeout_d;
  logic [7:0] hold_q, hold_d;
  logic [3:0] din;
  logic [1:0] cand;
  logic [1:0] winner;
  logic       win_any;

  // Search starts one past the last winner so the previous owner is tried last.
  always_comb begin
    cand    = last_q;
    winner  = last_q;
    win_any = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cand = last_q + 2'(i);
      if (!win_any && bus.req[cand]) begin
        winner  = cand;
        win_any = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    valid_d   = valid_q;
    last_d    = last_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        gnt_d   = '0;
        valid_d = 1'b0;
        if (win_any) begin
          state_d = GRANT;
          gnt_d   = 4'b0001 << winner;
          sel_d   = winner;
          valid_d = 1'b1;
          last_d  = winner;
          hold_d  = '0;
        end
      end
      GRANT: begin
        if (!bus.req[sel_q]) begin
          state_d = IDLE;
          gnt_d   = '0;
          valid_d = 1'b0;
        end
`ifdef MUX_ARB_TIMEOUT_EN
        else if (hold_q == HOLD_LAST) begin
          state_d   = IDLE;
          gnt_d     = '0;
          valid_d   = 1'b0;
          timeout_d = 1'b1;
        end
`endif
        else if (hold_q != 8'hff) begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      sel_q     <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      hold_q    <= '0;
      last_q    <= 2'd3;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      hold_q    <= hold_d;
      last_q    <= last_d;
    end
  end

`ifndef MUX_ARB_TIMEOUT_EN
  logic unused_hold_last;
  assign unused_hold_last = ^HOLD_LAST;
`endif

  assign din         = {bus.in3, bus.in2, bus.in1, bus.in0};
  assign bus.gnt     = gnt_q;
  assign bus.sel     = sel_q;
  assign bus.valid   = valid_q;
  assign bus.timeout = timeout_q;
  assign bus.out     = valid_q & din[sel_q];
endmodule

// File: tb/tb_mux_4_arbiter.sv
// tb/tb_mux_4_arbiter.sv - vector table, corner sequences and randomized model check for mux_4_arbiter
module tb_mux_4_arbiter;
  localparam int MAX_HOLD = 4;

  logic clk = 1'b0;
  logic reset;
  mux_4_arbiter_if bus();

  mux_4_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: who owns the channel, and for how many cycles so far.
  int   m_owner  = -1;
  int   m_sel    = 0;
  int   m_last   = 3;
  int   m_cycles = 0;
  int   m_to     = 0;
  logic ins [4];
  logic [3:0] rr;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic rst, input logic [3:0] req, input logic [3:0] gnt,
                     input logic [1:0] sel, input logic valid);
    vec_t v;
    v.rst = rst; v.req = req; v.gnt = gnt; v.sel = sel; v.valid = valid;
    vecs.push_back(v);
  endtask

  task automatic model_edge(input logic rst, input logic [3:0] r);
    int c;
    if (rst) begin
      m_owner = -1; m_sel = 0; m_last = 3; m_cycles = 0; m_to = 0;
    end else if (m_owner < 0) begin
      m_to = 0;
      for (int k = 1; k <= 4; k++) begin
        c = (m_last + k) % 4;
        if (m_owner < 0 && r[c]) begin
          m_owner = c; m_sel = c; m_last = c; m_cycles = 1;
        end
      end
    end else begin
      m_to = 0;
      if (!r[m_owner]) m_owner = -1;
`ifdef MUX_ARB_TIMEOUT_EN
      else if (m_cycles == MAX_HOLD) begin
        m_owner = -1;
        m_to    = 1;
      end
`endif
      else m_cycles++;
    end
  endtask

  task automatic step(input logic rst, input logic [3:0] r);
    for (int i = 0; i < 4; i++) ins[i] = 1'($urandom_range(0, 1));
    bus.in0 = ins[0];
    bus.in1 = ins[1];
    bus.in2 = ins[2];
    bus.in3 = ins[3];
    bus.req = r;
    reset   = rst;
    @(posedge clk);
    model_edge(rst, r);
    @(negedge clk);
    chk("model_gnt",   8'(bus.gnt),     (m_owner >= 0) ? 8'(4'b0001 << m_owner) : 8'h00);
    chk("model_sel",   8'(bus.sel),     8'(m_sel));
    chk("model_valid", 8'(bus.valid),   (m_owner >= 0) ? 8'h01 : 8'h00);
    chk("model_out",   8'(bus.out),     (m_owner >= 0) ? 8'(ins[m_owner]) : 8'h00);
    chk("model_tmo",   8'(bus.timeout), 8'(m_to));
  endtask

  initial begin
    reset   = 1'b1;
    bus.req = '0;
    bus.in0 = 1'b0;
    bus.in1 = 1'b0;
    bus.in2 = 1'b0;
    bus.in3 = 1'b0;

    // single requester, idle holds sel
    add(1, 4'b0000, 4'b0000, 2'd0, 0);
    add(0, 4'b0100, 4'b0100, 2'd2, 1);
    add(0, 4'b0100, 4'b0100, 2'd2, 1);
    add(0, 4'b0000, 4'b0000, 2'd2, 0);
    add(0, 4'b0000, 4'b0000, 2'd2, 0);
    // fairness with all requesting, one idle cycle between owners
    add(1, 4'b1111, 4'b0000, 2'd0, 0);
    add(0, 4'b1111, 4'b0001, 2'd0, 1);
    add(0, 4'b1111, 4'b0001, 2'd0, 1);
    add(0, 4'b1110, 4'b0000, 2'd0, 0);
    add(0, 4'b1111, 4'b0010, 2'd1, 1);
    add(0, 4'b1111, 4'b0010, 2'd1, 1);
    add(0, 4'b1101, 4'b0000, 2'd1, 0);
    add(0, 4'b1111, 4'b0100, 2'd2, 1);
    add(0, 4'b1111, 4'b0100, 2'd2, 1);
    add(0, 4'b1011, 4'b0000, 2'd2, 0);
    add(0, 4'b1111, 4'b1000, 2'd3, 1);
    add(0, 4'b1111, 4'b1000, 2'd3, 1);
    add(0, 4'b0111, 4'b0000, 2'd3, 0);
    add(0, 4'b1111, 4'b0001, 2'd0, 1);
    // wrap-around from last=3
    add(0, 4'b0000, 4'b0000, 2'd0, 0);
    add(0, 4'b1000, 4'b1000, 2'd3, 1);
    add(0, 4'b0000, 4'b0000, 2'd3, 0);
    add(0, 4'b1001, 4'b0001, 2'd0, 1);
    add(0, 4'b0000, 4'b0000, 2'd0, 0);
    add(0, 4'b1001, 4'b1000, 2'd3, 1);
    add(0, 4'b0000, 4'b0000, 2'd3, 0);
    // reset mid-grant
    add(0, 4'b0010, 4'b0010, 2'd1, 1);
    add(1, 4'b0010, 4'b0000, 2'd0, 0);
    add(0, 4'b0011, 4'b0001, 2'd0, 1);
    add(0, 4'b0000, 4'b0000, 2'd0, 0);

    @(negedge clk);
    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].req);
      chk($sformatf("vec%0d_gnt", i),   8'(bus.gnt),   8'(vecs[i].gnt));
      chk($sformatf("vec%0d_sel", i),   8'(bus.sel),   8'(vecs[i].sel));
      chk($sformatf("vec%0d_valid", i), 8'(bus.valid), 8'(vecs[i].valid));
    end

`ifdef MUX_ARB_TIMEOUT_EN
    step(1, 4'b0000);
    for (int i = 0; i < MAX_HOLD; i++) begin
      step(0, 4'b0011);
      chk("to_hold_gnt", 8'(bus.gnt), 8'h01);
    end
    step(0, 4'b0011);
    chk("to_release_gnt", 8'(bus.gnt),     8'h00);
    chk("to_pulse",       8'(bus.timeout), 8'h01);
    step(0, 4'b0011);
    chk("to_next_gnt",    8'(bus.gnt),     8'h02);
    chk("to_pulse_end",   8'(bus.timeout), 8'h00);
    step(1, 4'b0000);
    for (int i = 0; i < MAX_HOLD; i++) step(0, 4'b0001);
    step(0, 4'b0000);
    chk("to_drop_gnt",    8'(bus.gnt),     8'h00);
    chk("to_drop_pulse",  8'(bus.timeout), 8'h00);
`else
    step(1, 4'b0000);
    for (int i = 0; i < 300; i++) begin
      step(0, 4'b0001);
      chk("long_gnt", 8'(bus.gnt),     8'h01);
      chk("long_tmo", 8'(bus.timeout), 8'h00);
    end
`endif

    rr = '0;
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 3) == 0) rr = 4'($urandom_range(0, 15));
      step($urandom_range(0, 63) == 0, rr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
